// File: rtl/pipeline_ctrl.sv
// Central stall/bubble sequencer: ibus/dbus handshake FSMs, mul/div scheduler, wrong-path fetch drop.
// Latency: stall/bubble outputs are combinational from inputs and state; mul/div holds E for LAT cycles.
// Backpressure: a bus wait or mul/div run raises stalls, which outrank bubbles for the same register.
module pipeline_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 33,
    parameter int CNT_W    = 6
) (
    input  logic clk,
    input  logic resetn,
    input  logic d_hazard,
    input  logic e_redirect,
    input  logic e_md_start,
    input  logic e_md_is_div,
    input  logic i_req_valid,
    input  logic i_addr_ok,
    input  logic i_data_ok,
    input  logic d_req_valid,
    input  logic d_addr_ok,
    input  logic d_data_ok,
    output logic i_req,
    output logic d_req,
    output logic i_drop,
    output logic stall_f,
    output logic stall_d,
    output logic stall_e,
    output logic stall_m,
    output logic bubble_d,
    output logic bubble_e,
    output logic bubble_m,
    output logic md_busy,
    output logic md_done
);

    typedef enum logic {BUS_IDLE, BUS_WAIT} bus_st_t;
    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_st_t;

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

    bus_st_t i_st, i_nxt, d_st, d_nxt;
    md_st_t  md_st, md_nxt;
    logic [CNT_W-1:0] md_cnt, md_cnt_nxt;
    logic drop_q, drop_nxt;

    logic i_req_c, d_req_c, i_wait, d_wait, mem_wait;
    logic md_stall, md_done_c, md_busy_c;
    logic stall_e_c, stall_d_c, i_pending, redir, i_drop_c;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_st   <= BUS_IDLE;
            d_st   <= BUS_IDLE;
            md_st  <= MD_IDLE;
            md_cnt <= '0;
            drop_q <= 1'b0;
        end else begin
            i_st   <= i_nxt;
            d_st   <= d_nxt;
            md_st  <= md_nxt;
            md_cnt <= md_cnt_nxt;
            drop_q <= drop_nxt;
        end
    end

    // An address accepted without same-cycle data leaves the bus waiting for data_ok.
    always_comb begin
        i_nxt   = i_st;
        i_req_c = 1'b0;
        i_wait  = 1'b0;
        case (i_st)
            BUS_IDLE: begin
                i_req_c = i_req_valid;
                i_wait  = i_req_valid & ~(i_addr_ok & i_data_ok);
                if (i_req_valid && i_addr_ok && !i_data_ok) i_nxt = BUS_WAIT;
            end
            BUS_WAIT: begin
                i_wait = ~i_data_ok;
                if (i_data_ok) i_nxt = BUS_IDLE;
            end
            default: i_nxt = BUS_IDLE;
        endcase
    end

    always_comb begin
        d_nxt   = d_st;
        d_req_c = 1'b0;
        d_wait  = 1'b0;
        case (d_st)
            BUS_IDLE: begin
                d_req_c = d_req_valid;
                d_wait  = d_req_valid & ~(d_addr_ok & d_data_ok);
                if (d_req_valid && d_addr_ok && !d_data_ok) d_nxt = BUS_WAIT;
            end
            BUS_WAIT: begin
                d_wait = ~d_data_ok;
                if (d_data_ok) d_nxt = BUS_IDLE;
            end
            default: d_nxt = BUS_IDLE;
        endcase
    end

    assign mem_wait = d_wait;

    // DONE leaves on ~stall_e; md_stall is 0 there, so mem_wait alone decides.
    always_comb begin
        md_nxt     = md_st;
        md_cnt_nxt = md_cnt;
        md_stall   = 1'b0;
        md_done_c  = 1'b0;
        md_busy_c  = 1'b0;
        case (md_st)
            MD_IDLE: begin
                if (e_md_start) begin
                    md_stall  = 1'b1;
                    md_busy_c = 1'b1;
                    if (!mem_wait) begin
                        md_cnt_nxt = e_md_is_div ? DIV_CNT : MULT_CNT;
                        md_nxt     = MD_RUN;
                    end
                end
            end
            MD_RUN: begin
                md_stall   = 1'b1;
                md_busy_c  = 1'b1;
                md_cnt_nxt = md_cnt - CNT_W'(1);
                if (md_cnt == CNT_W'(1)) md_nxt = MD_DONE;
            end
            MD_DONE: begin
                md_done_c = 1'b1;
                md_busy_c = 1'b1;
                if (!mem_wait) md_nxt = MD_IDLE;
            end
            default: md_nxt = MD_IDLE;
        endcase
    end

    assign stall_e_c = mem_wait | md_stall;
    assign stall_d_c = stall_e_c | d_hazard;

    // Data arriving in the redirect cycle is the delay slot, so only a still-pending fetch is marked.
    assign i_pending = (i_st == BUS_WAIT) | ((i_st == BUS_IDLE) & i_req_valid & i_addr_ok);
    assign redir     = e_redirect & ~stall_e_c;
    assign i_drop_c  = drop_q & i_data_ok;
    assign drop_nxt  = ((redir & i_pending) | drop_q) & ~i_data_ok;

    assign i_req    = resetn & i_req_c;
    assign d_req    = resetn & d_req_c;
    assign i_drop   = resetn & i_drop_c;
    assign stall_m  = resetn & mem_wait;
    assign stall_e  = resetn & stall_e_c;
    assign stall_d  = resetn & stall_d_c;
    assign stall_f  = resetn & (stall_d_c | i_wait | drop_q);
    assign bubble_m = resetn & md_stall & ~mem_wait;
    assign bubble_e = resetn & d_hazard & ~stall_e_c;
    assign bubble_d = resetn & (i_wait | i_drop_c | (drop_q & ~i_data_ok)) & ~stall_d_c;
    assign md_busy  = resetn & md_busy_c;
    assign md_done  = resetn & md_done_c;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: per-cycle expected output vectors queued at drive time.
// Latency: outputs compared half a cycle after inputs are applied.
// Backpressure: none; every step is a fixed single cycle.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic resetn;
    logic d_hazard, e_redirect, e_md_start, e_md_is_div;
    logic i_req_valid, i_addr_ok, i_data_ok;
    logic d_req_valid, d_addr_ok, d_data_ok;
    logic i_req, d_req, i_drop, stall_f, stall_d, stall_e, stall_m;
    logic bubble_d, bubble_e, bubble_m, md_busy, md_done;

    localparam logic [11:0] IREQ = 12'h800, DREQ = 12'h400, IDROP = 12'h200;
    localparam logic [11:0] SF = 12'h100, SD = 12'h080, SE = 12'h040, SM = 12'h020;
    localparam logic [11:0] BD = 12'h010, BE = 12'h008, BM = 12'h004;
    localparam logic [11:0] BUSY = 12'h002, DONE = 12'h001;
    localparam logic [11:0] MEMST = SM | SE | SD | SF;
    localparam logic [11:0] MDRUN = SE | SD | SF | BM | BUSY;

    int checks = 0;
    int failures = 0;
    logic [11:0] exp_q[$];
    string tag_q[$];

    pipeline_ctrl #(.MULT_LAT(4), .DIV_LAT(33), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn),
        .d_hazard(d_hazard), .e_redirect(e_redirect),
        .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
        .i_req_valid(i_req_valid), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .d_req_valid(d_req_valid), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .i_req(i_req), .d_req(d_req), .i_drop(i_drop),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .bubble_d(bubble_d), .bubble_e(bubble_e), .bubble_m(bubble_m),
        .md_busy(md_busy), .md_done(md_done)
    );

    always #5 clk = ~clk;

    wire [11:0] obs = {i_req, d_req, i_drop, stall_f, stall_d, stall_e, stall_m,
                       bubble_d, bubble_e, bubble_m, md_busy, md_done};

    task automatic clr();
        d_hazard = 0; e_redirect = 0; e_md_start = 0; e_md_is_div = 0;
        i_req_valid = 0; i_addr_ok = 0; i_data_ok = 0;
        d_req_valid = 0; d_addr_ok = 0; d_data_ok = 0;
    endtask

    // Inputs are already driven; queue the expectation, check at negedge, advance to next cycle.
    task automatic cyc(input logic [11:0] exp, input string tag);
        logic [11:0] e;
        string t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        resetn = 0;
        @(posedge clk); #1;
        cyc(12'h000, "reset_idle");
        resetn = 1;
        cyc(12'h000, "post_reset_idle");

        // load-use hazard
        d_hazard = 1;
        cyc(SF | SD | BE, "load_use");
        d_hazard = 0;
        cyc(12'h000, "load_use_clear");

        // dbus: addr accepted, data three cycles later
        d_req_valid = 1; d_addr_ok = 1;
        cyc(DREQ | MEMST, "dbus_addr");
        d_addr_ok = 0;
        cyc(MEMST, "dbus_wait1");
        cyc(MEMST, "dbus_wait2");
        d_data_ok = 1;
        cyc(12'h000, "dbus_data");
        clr();
        // dbus: addr_ok delayed a cycle
        d_req_valid = 1;
        cyc(DREQ | MEMST, "dbus_noaddr");
        d_addr_ok = 1;
        cyc(DREQ | MEMST, "dbus_late_addr");
        d_addr_ok = 0;
        cyc(MEMST, "dbus_late_wait");
        d_data_ok = 1;
        cyc(12'h000, "dbus_late_data");
        clr();
        // dbus zero-wait
        d_req_valid = 1; d_addr_ok = 1; d_data_ok = 1;
        cyc(DREQ, "dbus_zero_wait");
        clr();

        // MULT: 4 stalled cycles, done held with start still high (ignored)
        e_md_start = 1; e_md_is_div = 0;
        for (int k = 0; k < 4; k++) cyc(MDRUN, $sformatf("mult_run%0d", k));
        cyc(DONE | BUSY, "mult_done");
        clr();
        cyc(12'h000, "mult_idle");

        // DIV: 33 stalled cycles
        e_md_start = 1; e_md_is_div = 1;
        for (int k = 0; k < 33; k++) cyc(MDRUN, $sformatf("div_run%0d", k));
        cyc(DONE | BUSY, "div_done");
        clr();
        cyc(12'h000, "div_idle");

        // overlap: MULT running while dbus waits; done held until mem wait ends
        e_md_start = 1;
        cyc(MDRUN, "ovl_start");
        d_req_valid = 1; d_addr_ok = 1;
        cyc(DREQ | MEMST | BUSY, "ovl_run_addr");
        d_addr_ok = 0;
        cyc(MEMST | BUSY, "ovl_run_wait1");
        cyc(MEMST | BUSY, "ovl_run_wait2");
        cyc(MEMST | BUSY | DONE, "ovl_done_held");
        d_data_ok = 1;
        cyc(BUSY | DONE, "ovl_done_release");
        clr();
        cyc(12'h000, "ovl_idle");

        // wrong-path drop
        i_req_valid = 1; i_addr_ok = 1;
        cyc(IREQ | SF | BD, "ibus_addr");
        i_addr_ok = 0; e_redirect = 1;
        cyc(SF | BD, "ibus_wait_redir");
        e_redirect = 0;
        cyc(SF | BD, "ibus_wait_drop1");
        cyc(SF | BD, "ibus_wait_drop2");
        i_data_ok = 1;
        cyc(IDROP | SF | BD, "ibus_drop");
        i_addr_ok = 1;
        cyc(IREQ, "ibus_after_drop");
        clr();
        cyc(12'h000, "ibus_idle");

        // redirect with same-cycle data is the delay slot
        i_req_valid = 1; i_addr_ok = 1;
        cyc(IREQ | SF | BD, "slot_addr");
        i_addr_ok = 0; e_redirect = 1; i_data_ok = 1;
        cyc(12'h000, "slot_redir_data");
        e_redirect = 0; i_addr_ok = 1;
        cyc(IREQ, "slot_next_fetch");
        clr();

        // redirect masked by stall_e
        i_req_valid = 1; i_addr_ok = 1;
        cyc(IREQ | SF | BD, "mask_addr");
        i_addr_ok = 0; e_redirect = 1; d_req_valid = 1; d_addr_ok = 1;
        cyc(DREQ | MEMST, "mask_redir_stalled");
        clr();
        i_data_ok = 1; d_data_ok = 1;
        cyc(12'h000, "mask_no_drop");
        clr();

        // reset mid-transaction: DIV running and dbus waiting
        e_md_start = 1; e_md_is_div = 1;
        cyc(MDRUN, "rst_div_start");
        d_req_valid = 1; d_addr_ok = 1;
        cyc(DREQ | MEMST | BUSY, "rst_dbus_addr");
        d_addr_ok = 0;
        resetn = 0;
        cyc(12'h000, "rst_mid_txn");
        clr();
        cyc(12'h000, "rst_held");
        resetn = 1;
        cyc(12'h000, "rst_release");
        d_hazard = 1;
        cyc(SF | SD | BE, "rst_after_hazard");
        clr();
        cyc(12'h000, "final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline (F/D/E/M/W).
- Tracks outstanding instruction-bus and data-bus transactions with per-bus handshake FSMs.
- Schedules the shared multi-cycle mul/div unit that writes HI/LO.
- Merges these with the Decode load-use hazard and the Execute redirect to produce per-stage stall and bubble controls, plus a wrong-path fetch-drop flag.

Parameters:
MULT_LAT, 4, total cycles E is held for MULT/MULTU, including the start cycle (must be >= 2)
DIV_LAT, 33, total cycles E is held for DIV/DIVU, including the start cycle (must be >= 2)
CNT_W, 6, width of the mul/div down-counter (must hold DIV_LAT-1)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
d_hazard  in  1  load-use hazard from Decode
e_redirect  in  1  branch/jump taken, resolved in E
e_md_start  in  1  E holds a mul/div instruction; held high while the instruction sits in E
e_md_is_div  in  1  1 = DIV/DIVU, 0 = MULT/MULTU; sampled with e_md_start
i_req_valid  in  1  Fetch wants an instruction
i_addr_ok  in  1  ibus accepted the address
i_data_ok  in  1  ibus returned data
d_req_valid  in  1  M stage wants a data access
d_addr_ok  in  1  dbus accepted the address
d_data_ok  in  1  dbus returned data or write acknowledge
i_req  out  1  ibus request strobe
d_req  out  1  dbus request strobe
i_drop  out  1  the current i_data_ok carries a wrong-path instruction; Fetch must discard it
stall_f, stall_d, stall_e, stall_m  out  1 each  hold the corresponding pipeline register
bubble_d, bubble_e, bubble_m  out  1 each  load a NOP into the corresponding pipeline register
md_busy  out  1  mul/div unit occupied
md_done  out  1  HI/LO result valid this cycle

Behaviour:
Reset:
- resetn low forces immediately: both bus FSMs to IDLE, md FSM to IDLE, md_cnt=0, drop_q=0, every output 0.
- Reset mid-transaction abandons it; no stall is held after release.

Bus FSMs (IBUS and DBUS are identical; x = i or d):
- IDLE:
  - x_req = x_req_valid.
  - If x_req_valid with x_addr_ok and x_data_ok together: stay IDLE, no wait.
  - If x_req_valid with x_addr_ok only: go to WAIT.
  - If x_req_valid without x_addr_ok: stay IDLE and wait.
- WAIT: x_req=0; wait until x_data_ok, then return to IDLE; no wait in the data_ok cycle.
- x_wait = (IDLE & x_req_valid & ~(x_addr_ok & x_data_ok)) | (WAIT & ~x_data_ok).

MD FSM:
- IDLE:
  - e_md_start & ~mem_wait: md_cnt <= LAT-1 (LAT chosen by e_md_is_div); go to RUN.
  - md_stall=1 in this start cycle.
- RUN:
  - md_stall=1; md_cnt decrements.
  - When md_cnt==1, go to DONE.
- DONE:
  - md_done=1, md_stall=0.
  - Go to IDLE when ~stall_e; otherwise stay DONE.
  - e_md_start is ignored while in DONE.
- md_busy = RUN | DONE | (IDLE & e_md_start).
- Net effect: stall_e is high for exactly LAT cycles; md_done follows in the next cycle.

Drop flag:
- redir = e_redirect & ~stall_e.
- On redir, drop_q is set if the ibus has a wrong-path fetch pending and no i_data_ok arrives this cycle. Pending means IBUS in WAIT, or IDLE with i_req_valid & i_addr_ok.
- i_drop = drop_q & i_data_ok; the drop clears drop_q.
- Same-cycle redir and i_data_ok: that data is the delay slot, not dropped.
- A second redir while drop_q is set leaves drop_q set.

Stall/bubble equations (combinational):
- mem_wait = d_wait
- stall_m = mem_wait
- stall_e = mem_wait | md_stall
- stall_d = stall_e | d_hazard
- stall_f = stall_d | i_wait | drop_q
- bubble_m = md_stall & ~mem_wait
- bubble_e = d_hazard & ~stall_e
- bubble_d = (i_wait | i_drop | (drop_q & ~i_data_ok)) & ~stall_d
- A stall always outranks a bubble for the same register.
- Holding instruction data that arrives during stall_d is Fetch's responsibility.

Test Plan:
- Reset: resetn=0 during DBUS WAIT with MD in RUN -> all outputs 0 immediately. After release with d_req_valid=0, stall_m=0 in the first cycle.
- Load-use: d_hazard=1 for 1 cycle, no bus waits -> stall_f=stall_d=1, bubble_e=1, stall_e=0 that cycle; all 0 the next cycle.
- MULT: e_md_start=1, e_md_is_div=0 at cycle 10 -> stall_e=1 and bubble_m=1 on cycles 10-13; md_done=1 on cycle 14; MD FSM back to IDLE at cycle 15. DIV started at cycle 10 -> stall_e on cycles 10-42, md_done on cycle 43.
- Dbus wait: d_req_valid=1, d_addr_ok=1 at cycle 5, d_data_ok at cycle 8 -> stall_m=stall_e=1 on cycles 5-7, 0 on cycle 8. With d_addr_ok delayed to cycle 6, d_req=1 on cycles 5-6 only.
- Wrong-path drop: IBUS in WAIT, e_redirect=1 at cycle 3, i_data_ok at cycle 6 -> drop_q set at cycle 4; i_drop=1 and bubble_d=1 on cycle 6; drop_q=0 on cycle 7.
- Overlap: md RUN plus DBUS WAIT in the same cycle -> stall_m=stall_e=1, bubble_m=0; md_cnt keeps counting; md_done is held until stall_e drops.
